// File: rtl/rf_arb_pkg.sv
// Shared types and the round-robin grant function for the register-file write arbiter.
package rf_arb_pkg;

    typedef enum logic {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam int MAX_REQ = 8;

    // One-hot grant on the first valid requester found from ptr upward, modulo nreq.
    function automatic logic [MAX_REQ-1:0] rr_grant(input logic [MAX_REQ-1:0] valid,
                                                    input int unsigned        ptr,
                                                    input int unsigned        nreq);
        logic [MAX_REQ-1:0] g;
        logic               found;
        int unsigned        idx;
        g     = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            if (k < nreq) begin
                idx = (ptr + k) % nreq;
                if (!found && valid[idx[2:0]]) begin
                    g[idx[2:0]] = 1'b1;
                    found       = 1'b1;
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant plus the rotating priority pointer.
module rr_arbiter
    import rf_arb_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] valid,
    input  logic            enable,
    input  logic            update,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx
);

    logic [IW-1:0]      rr_ptr;
    logic [MAX_REQ-1:0] valid_ext;
    logic [MAX_REQ-1:0] grant_ext;

    always_comb begin
        valid_ext             = '0;
        valid_ext[NREQ-1:0]   = valid;
        grant_ext             = rr_grant(valid_ext, 32'(rr_ptr), NREQ);
        grant                 = enable ? grant_ext[NREQ-1:0] : '0;
    end

    always_comb begin
        idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) idx = IW'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (update) begin
            rr_ptr <= (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter with a clear sequencer for addresses 1..2**AWL-1.
// Optional write statistics counter enabled by defining RF_ARB_STATS_EN.
//
// state | meaning
// ARB   | round-robin grants, one registered write per handshake
// CLEAR | sequencer writes zero to every writable address, requests stalled
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AWL  = 5,
    parameter int DWL  = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*AWL-1:0] req_addr,
    input  logic [NREQ*DWL-1:0] req_data,
    output logic [NREQ-1:0]     req_ready,
    input  logic                clear_start,
    output logic                busy,
    output logic                clear_done,
    output logic                rf_wen,
    output logic [AWL-1:0]      rf_wa,
    output logic [DWL-1:0]      rf_wd
`ifdef RF_ARB_STATS_EN
   ,output logic [31:0]         wr_count
`endif
);

    localparam int            IW      = $clog2(NREQ);
    localparam logic [AWL-1:0] CNT_MAX = {AWL{1'b1}};

    state_t         state;
    state_t         state_next;
    logic [AWL-1:0] clr_cnt;
    logic           arb_en;
    logic           hs;
    logic [IW-1:0]  gnt_idx;
    logic [AWL-1:0] sel_addr;
    logic [DWL-1:0] sel_data;

    // rst_n gates the grant so req_ready is low for the whole reset interval.
    assign arb_en   = rst_n && (state == ARB) && !clear_start;
    assign hs       = |req_ready;
    assign sel_addr = req_addr[gnt_idx*AWL +: AWL];
    assign sel_data = req_data[gnt_idx*DWL +: DWL];
    assign busy     = (state == CLEAR);

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid  (req_valid),
        .enable (arb_en),
        .update (hs),
        .grant  (req_ready),
        .idx    (gnt_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ARB;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ARB:     if (clear_start)        state_next = CLEAR;
            CLEAR:   if (clr_cnt == CNT_MAX) state_next = ARB;
            default:                         state_next = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_cnt    <= '0;
            rf_wen     <= 1'b0;
            rf_wa      <= '0;
            rf_wd      <= '0;
            clear_done <= 1'b0;
        end else begin
            clear_done <= (state == CLEAR) && (clr_cnt == CNT_MAX);
            if (state == CLEAR) begin
                rf_wen  <= 1'b1;
                rf_wa   <= clr_cnt;
                rf_wd   <= '0;
                clr_cnt <= clr_cnt + 1'b1;
            end else begin
                if (clear_start) clr_cnt <= AWL'(1);
                // Register 0 is hardwired: the handshake completes but no write is issued.
                rf_wen <= hs && (sel_addr != '0);
                if (hs) begin
                    rf_wa <= sel_addr;
                    rf_wd <= sel_data;
                end
            end
        end
    end

`ifdef RF_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       wr_count <= '0;
        else if (hs && sel_addr != '0)    wr_count <= wr_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter (NREQ=4, AWL=5, DWL=32).
module tb_rf_write_arbiter;

    localparam int NREQ = 4;
    localparam int AWL  = 5;
    localparam int DWL  = 32;

    logic                clk;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*AWL-1:0] req_addr;
    logic [NREQ*DWL-1:0] req_data;
    logic [NREQ-1:0]     req_ready;
    logic                clear_start;
    logic                busy;
    logic                clear_done;
    logic                rf_wen;
    logic [AWL-1:0]      rf_wa;
    logic [DWL-1:0]      rf_wd;
`ifdef RF_ARB_STATS_EN
    logic [31:0]         wr_count;
`endif

    int errors = 0;
    int checks = 0;
    int done_cnt;

    rf_write_arbiter #(.NREQ(NREQ), .AWL(AWL), .DWL(DWL)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .clear_start (clear_start),
        .busy        (busy),
        .clear_done  (clear_done),
        .rf_wen      (rf_wen),
        .rf_wa       (rf_wa),
        .rf_wd       (rf_wd)
`ifdef RF_ARB_STATS_EN
       ,.wr_count    (wr_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AWL-1:0] a, input logic [DWL-1:0] d);
        req_addr[i*AWL +: AWL] = a;
        req_data[i*DWL +: DWL] = d;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_wen"},   64'(rf_wen),     64'd0);
        check({tag, "_wa"},    64'(rf_wa),      64'd0);
        check({tag, "_wd"},    64'(rf_wd),      64'd0);
        check({tag, "_busy"},  64'(busy),       64'd0);
        check({tag, "_done"},  64'(clear_done), 64'd0);
        check({tag, "_ready"}, 64'(req_ready),  64'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        req_valid   = '0;
        req_addr    = '0;
        req_data    = '0;
        clear_start = 1'b0;
        #3;
        check_idle_outputs("por");
        tick();
        rst_n = 1'b1;

        // 1: async reset mid-stream, then lone requester 2
        set_req(0, 5'd3, 32'h33);
        req_valid = 4'b0001;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rst_mid");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_valid = 4'b0100;
        set_req(2, 5'd9, 32'h99);
        #1;
        check("t1_ready", 64'(req_ready), 64'b0100);
        tick();
        check("t1_wen", 64'(rf_wen), 64'd1);
        check("t1_wa",  64'(rf_wa),  64'd9);
        check("t1_wd",  64'(rf_wd),  64'h99);

        // move pointer back to 0 via requester 3
        set_req(3, 5'd20, 32'h3030);
        req_valid = 4'b1000;
        #1;
        check("ptr3_ready", 64'(req_ready), 64'b1000);
        tick();
        check("ptr3_wa", 64'(rf_wa), 64'd20);

        // 2: fairness with all requesters valid
        for (int i = 0; i < NREQ; i++) set_req(i, AWL'(i + 4), 32'h100 + 32'(i));
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("rr_ready", 64'(req_ready), 64'(4'b0001 << (k % 4)));
            tick();
            check("rr_wen", 64'(rf_wen), 64'd1);
            check("rr_wa",  64'(rf_wa),  64'((k % 4) + 4));
            check("rr_wd",  64'(rf_wd),  64'h100 + 64'(k % 4));
        end
        req_valid = '0;
        tick();
        check("nogrant_wen", 64'(rf_wen), 64'd0);
        check("nogrant_wa",  64'(rf_wa),  64'd7);
        check("nogrant_wd",  64'(rf_wd),  64'h103);

        // 3: address 0 handshake
        set_req(1, 5'd0, 32'hDEADBEEF);
        req_valid = 4'b0010;
        #1;
        check("a0_ready", 64'(req_ready), 64'b0010);
        tick();
        check("a0_wen", 64'(rf_wen), 64'd0);
        set_req(1, 5'd5, 32'h101);
        req_valid = 4'b1111;
        #1;
        check("a0_ptr_ready", 64'(req_ready), 64'b0100);
        tick();
        check("a0_ptr_wa", 64'(rf_wa), 64'd6);
        req_valid = '0;

        // 4: clear with requester 0 pending, restart attempt ignored
        set_req(0, 5'd7, 32'h77);
        req_valid   = 4'b0001;
        clear_start = 1'b1;
        #1;
        check("clr_start_ready", 64'(req_ready), 64'd0);
        tick();
        clear_start = 1'b0;
        check("clr_first_wen", 64'(rf_wen),    64'd0);
        check("clr_busy0",     64'(busy),      64'd1);
        check("clr_ready0",    64'(req_ready), 64'd0);
        done_cnt = 0;
        for (int k = 1; k <= 31; k++) begin
            tick();
            clear_start = 1'b0;
            if (clear_done) done_cnt++;
            check("clr_wen", 64'(rf_wen), 64'd1);
            check("clr_wa",  64'(rf_wa),  64'(k));
            check("clr_wd",  64'(rf_wd),  64'd0);
            if (k < 31) begin
                check("clr_busy",  64'(busy),       64'd1);
                check("clr_done",  64'(clear_done), 64'd0);
                check("clr_ready", 64'(req_ready),  64'd0);
            end else begin
                check("clr_end_busy",  64'(busy),       64'd0);
                check("clr_end_done",  64'(clear_done), 64'd1);
                check("clr_end_ready", 64'(req_ready),  64'b0001);
            end
            if (k == 5) clear_start = 1'b1;
        end
        tick();
        if (clear_done) done_cnt++;
        check("clr_done_pulses", 64'(done_cnt), 64'd1);
        check("post_clr_wen", 64'(rf_wen), 64'd1);
        check("post_clr_wa",  64'(rf_wa),  64'd7);
        check("post_clr_wd",  64'(rf_wd),  64'h77);
        req_valid = '0;

        // 5: reset aborts a clear at address 10
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        for (int k = 1; k <= 10; k++) tick();
        check("abort_wa_before", 64'(rf_wa), 64'd10);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("abort");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("abort_done", 64'(clear_done), 64'd0);
            check("abort_busy", 64'(busy),       64'd0);
        end
        set_req(0, 5'd11, 32'h11);
        req_valid = 4'b0001;
        #1;
        check("abort_arb_ready", 64'(req_ready), 64'b0001);
        tick();
        check("abort_arb_wa", 64'(rf_wa), 64'd11);
        req_valid = '0;

`ifdef RF_ARB_STATS_EN
        // 6: statistics, one write already made since reset
        for (int j = 1; j <= 4; j++) begin
            set_req(2, AWL'(12 + j), 32'h200 + 32'(j));
            req_valid = 4'b0100;
            tick();
            req_valid = '0;
            tick();
        end
        set_req(3, 5'd0, 32'h5555);
        req_valid = 4'b1000;
        tick();
        req_valid   = '0;
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        for (int k = 0; k < 34; k++) tick();
        check("stats_count", 64'(wr_count), 64'd5);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
